// File: rtl/bit_count_launcher.sv
// bit_count_launcher: control stage between the raw DE1 KEY/SW inputs and
// the bit_counter datapath. It synchronizes and debounces the active-low
// start button, snapshots the switch operand into A, and drives bit_counter's
// level-style start. start is held high through done and dropped low to
// re-arm. A sticky err flag is set when a run never reports done.
//
// Optional build feature: define LAUNCH_COUNT_EN to add an 8-bit wrapping
// launch_count output that the board top routes to LEDR.
module bit_count_launcher #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DROP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             key_start_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             done,
    output logic [WIDTH-1:0] A,
    output logic             start,
    output logic             busy,
    output logic             err
`ifdef LAUNCH_COUNT_EN
    ,
    output logic [7:0]       launch_count
`endif
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TM_W = $clog2(TIMEOUT_CYCLES);
    localparam int DR_W = $clog2(DROP_CYCLES + 1);
    localparam int FL_W = $clog2(SYNC_STAGES + 1);

    localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] TM_ZERO = {TM_W{1'b0}};
    localparam logic [TM_W-1:0] TM_ONE  = TM_W'(1);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DR_W-1:0] DR_ZERO = {DR_W{1'b0}};
    localparam logic [DR_W-1:0] DR_ONE  = DR_W'(1);
    // DROP is one cycle shorter than DROP_CYCLES because the LOAD cycle that
    // follows also keeps start low; together they give DROP_CYCLES low cycles.
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DROP_CYCLES - 2);
    localparam logic [FL_W-1:0] FL_ZERO = {FL_W{1'b0}};
    localparam logic [FL_W-1:0] FL_ONE  = FL_W'(1);
    localparam logic [FL_W-1:0] FL_FULL = FL_W'(SYNC_STAGES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FL_W-1:0]        fill_q, fill_d;
    logic                   synced_s;
    logic                   sync_valid_s;
    logic                   deb_level_q, deb_level_d;
    logic [DB_W-1:0]        deb_cnt_q, deb_cnt_d;
    logic                   armed_q, armed_d;
    logic                   press_q, press_d;

    logic [2:0]             state_q, state_d;
    logic [TM_W-1:0]        timer_q, timer_d;
    logic [DR_W-1:0]        drop_q, drop_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic                   err_q, err_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic [7:0]             lc_q, lc_d;

    assign synced_s     = sync_q[SYNC_STAGES-1];
    assign sync_valid_s = (fill_q == FL_FULL);

    // Shift the raw button into the synchronizer and track when the chain
    // holds real samples rather than its released-level reset contents.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], key_start_n};
        if (fill_q == FL_FULL) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + FL_ONE;
        end
    end

    // Debounce the synced level and emit a one-cycle press pulse on a
    // released->pressed change. A press only counts once the button has been
    // seen released after reset, so a button held through reset cannot launch.
    always_comb begin
        deb_level_d = deb_level_q;
        deb_cnt_d   = DB_ZERO;
        press_d     = 1'b0;
        armed_d     = armed_q | (sync_valid_s & synced_s & deb_level_q);
        if (synced_s != deb_level_q) begin
            if (deb_cnt_q == DB_LAST) begin
                deb_level_d = synced_s;
                deb_cnt_d   = DB_ZERO;
                press_d     = armed_q & ~synced_s;
            end else begin
                deb_cnt_d   = deb_cnt_q + DB_ONE;
            end
        end else begin
            deb_cnt_d = DB_ZERO;
        end
    end

    // Launch sequencing: IDLE -> LOAD -> RUN -> DONE -> DROP -> LOAD ...
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        drop_d  = drop_q;
        a_d     = a_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                timer_d = TM_ZERO;
                drop_d  = DR_ZERO;
                if (press_q) begin
                    state_d = S_LOAD;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                a_d     = sw;
                timer_d = TM_ZERO;
                state_d = S_RUN;
            end
            S_RUN: begin
                // done in the first RUN cycle is left over from the previous
                // run and is ignored; done beats a coincident timeout.
                if ((timer_q != TM_ZERO) && done) begin
                    state_d = S_DONE;
                end else if (timer_q == TM_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TM_ONE;
                end
            end
            S_DONE: begin
                if (press_q) begin
                    state_d = S_DROP;
                    drop_d  = DR_ZERO;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DROP: begin
                if (drop_q == DR_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    drop_d  = drop_q + DR_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = TM_ZERO;
                drop_d  = DR_ZERO;
            end
        endcase
    end

    // Decode registered outputs from the next state so they line up with it.
    always_comb begin
        start_d = (state_d == S_RUN) || (state_d == S_DONE);
        busy_d  = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_DROP);
        if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
            lc_d = lc_q + 8'd1;
        end else begin
            lc_d = lc_q;
        end
    end

    // State and output registers, all cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= {SYNC_STAGES{1'b1}};
            fill_q      <= FL_ZERO;
            deb_level_q <= 1'b1;
            deb_cnt_q   <= DB_ZERO;
            armed_q     <= 1'b0;
            press_q     <= 1'b0;
            state_q     <= S_IDLE;
            timer_q     <= TM_ZERO;
            drop_q      <= DR_ZERO;
            a_q         <= {WIDTH{1'b0}};
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            lc_q        <= 8'd0;
        end else begin
            sync_q      <= sync_d;
            fill_q      <= fill_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            armed_q     <= armed_d;
            press_q     <= press_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            drop_q      <= drop_d;
            a_q         <= a_d;
            err_q       <= err_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            lc_q        <= lc_d;
        end
    end

    assign A     = a_q;
    assign start = start_q;
    assign busy  = busy_q;
    assign err   = err_q;

`ifdef LAUNCH_COUNT_EN
    assign launch_count = lc_q;
`else
    logic unused_lc_s;
    assign unused_lc_s = ^lc_q;
`endif

endmodule

// File: tb/tb_bit_count_launcher.sv
// Self-checking bench for bit_count_launcher. A behavioural model tracks the
// button path as sample history plus a run length of disagreeing samples, and
// the launcher as a phase with a cycle count; every cycle the DUT outputs are
// compared with it. Directed scenarios are followed by randomized presses.
module tb_bit_count_launcher;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int DROPC = 2;
    localparam int TO    = 16;

    localparam int P_IDLE = 10;
    localparam int P_LOAD = 11;
    localparam int P_RUN  = 12;
    localparam int P_DONE = 13;
    localparam int P_DROP = 14;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_start_n = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       done = 1'b0;
    logic [7:0] A;
    logic       start;
    logic       busy;
    logic       err;
`ifdef LAUNCH_COUNT_EN
    logic [7:0] launch_count;
`endif

    bit_count_launcher dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_start_n (key_start_n),
        .sw          (sw),
        .done        (done),
        .A           (A),
        .start       (start),
        .busy        (busy),
        .err         (err)
`ifdef LAUNCH_COUNT_EN
        ,
        .launch_count(launch_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    int         m_pipe[$];
    int         m_edges;
    int         m_level;
    int         m_run;
    bit         m_armed;
    bit         m_press;
    int         m_phase;
    int         m_cnt;
    logic [7:0] m_a;
    bit         m_err;
    int         m_launches;

    // stimulus helpers for the done line and span measurements
    int done_mode = 0;
    int done_lat  = 3;
    int run_cnt   = 0;
    int low_run   = 0;
    int last_low  = 0;
    int run_len   = 0;
    int last_run  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pipe = {};
        for (int i = 0; i < SYNC; i++) m_pipe.push_back(1);
        m_edges    = 0;
        m_level    = 1;
        m_run      = 0;
        m_armed    = 1'b0;
        m_press    = 1'b0;
        m_phase    = P_IDLE;
        m_cnt      = 0;
        m_a        = 8'h00;
        m_err      = 1'b0;
        m_launches = 0;
    endfunction

    function automatic void model_step();
        bit press_now;
        int synced;
        bit valid;
        bit arm_now;
        press_now = m_press;
        case (m_phase)
            P_IDLE: if (press_now) begin m_phase = P_LOAD; m_err = 1'b0; m_launches++; end
            P_LOAD: begin m_a = sw; m_phase = P_RUN; m_cnt = 0; end
            P_RUN: begin
                if (m_cnt >= 1 && done) m_phase = P_DONE;
                else if (m_cnt == TO - 1) begin m_phase = P_IDLE; m_err = 1'b1; end
                else m_cnt++;
            end
            P_DONE: if (press_now) begin m_phase = P_DROP; m_cnt = 0; end
            P_DROP: begin
                m_cnt++;
                if (m_cnt == DROPC - 1) begin m_phase = P_LOAD; m_launches++; end
            end
            default: m_phase = P_IDLE;
        endcase
        synced  = m_pipe[0];
        valid   = (m_edges >= SYNC);
        arm_now = valid && synced == 1 && m_level == 1;
        m_press = 1'b0;
        if (synced != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_level = synced;
                m_run   = 0;
                m_press = m_armed && (synced == 0);
            end
        end else begin
            m_run = 0;
        end
        if (arm_now) m_armed = 1'b1;
        void'(m_pipe.pop_front());
        m_pipe.push_back(int'(key_start_n));
        m_edges++;
    endfunction

    task automatic compare_outputs();
        check("start", start, (m_phase == P_RUN || m_phase == P_DONE));
        check("busy", busy, (m_phase == P_LOAD || m_phase == P_RUN || m_phase == P_DROP));
        check("A", A, m_a);
        check("err", err, m_err);
`ifdef LAUNCH_COUNT_EN
        check("launch_count", launch_count, m_launches & 255);
`endif
    endtask

    // One clock: step the model on the edge, compare just after it, then
    // update the bit_counter stand-in that drives done.
    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
        compare_outputs();
        if (start) begin
            low_run = 0;
            if (low_run == 0 && run_cnt == 0) last_low = last_low;
            run_cnt++;
        end else begin
            run_cnt = 0;
            low_run++;
        end
        if (start && busy) begin
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        case (done_mode)
            0:       done = (run_cnt >= done_lat);
            1:       done = 1'b0;
            2:       done = (run_cnt <= 1) || (run_cnt >= 6);
            default: done = 1'b0;
        endcase
    endtask

    // Records the length of the last start-low span when start returns high.
    int low_track = 0;
    task automatic tick_low();
        tick();
        if (!start) begin
            low_track++;
        end else if (low_track != 0) begin
            last_low  = low_track;
            low_track = 0;
        end
    endtask

    task automatic press(input int hold, input int rel, input bit jitter_sw);
        key_start_n = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick_low();
            if (jitter_sw) sw = 8'($urandom);
        end
        key_start_n = 1'b1;
        for (int i = 0; i < rel; i++) begin
            tick_low();
            if (jitter_sw) sw = 8'($urandom);
        end
    endtask

    task automatic bounce(input int n);
        for (int i = 0; i < n; i++) begin
            key_start_n = 1'b0;
            tick_low();
            key_start_n = 1'b1;
            tick_low();
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        repeat (3) tick_low();
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        // reset state
        repeat (3) tick_low();
        #2;
        reset_n = 1'b1;
        repeat (4) tick_low();

        // bounce: three one-cycle low pulses must not launch
        bounce(3);
        repeat (10) tick_low();
        check("bounce_A", A, 8'h00);
        check("bounce_busy", busy, 1'b0);
        check("bounce_start", start, 1'b0);

        // first clean launch, done after 9 cycles
        sw = 8'hA5; done_mode = 0; done_lat = 9;
        press(10, 10, 1'b0);
        repeat (10) tick_low();
        check("first_A", A, 8'hA5);
        check("first_done_start", start, 1'b1);
        check("first_done_busy", busy, 1'b0);

        // relaunch from DONE with a new operand
        sw = 8'h0F; done_lat = 4;
        press(10, 10, 1'b0);
        repeat (6) tick_low();
        check("relaunch_A", A, 8'h0F);
        check("relaunch_start", start, 1'b1);
        check("relaunch_err", err, 1'b0);
        check("drop_low_cycles", last_low, DROPC);

        // timeout: done never arrives
        done_mode = 1;
        press(10, 10, 1'b0);
        repeat (20) tick_low();
        check("timeout_err", err, 1'b1);
        check("timeout_start", start, 1'b0);
        check("timeout_busy", busy, 1'b0);
        check("timeout_run_len", last_run, TO);

        // next press clears err and relaunches
        done_mode = 0; done_lat = 4; sw = 8'h3C;
        press(10, 10, 1'b0);
        check("recover_err", err, 1'b0);
        check("recover_start", start, 1'b1);
        check("recover_A", A, 8'h3C);

        // done arriving exactly on the last RUN cycle beats the timeout
        done_lat = 16;
        press(10, 10, 1'b0);
        repeat (12) tick_low();
        check("tie_run_len", last_run, TO);
        check("tie_start", start, 1'b1);
        check("tie_err", err, 1'b0);

        // stale done on RUN entry, then low, then high on cycle 5
        done_mode = 2;
        press(10, 10, 1'b0);
        repeat (4) tick_low();
        check("stale_run_len", last_run, 6);
        check("stale_start", start, 1'b1);
        check("stale_busy", busy, 1'b0);

        // asynchronous reset mid-RUN with the button held through release
        done_mode = 1;
        key_start_n = 1'b0;
        repeat (SYNC + DEB + 4) tick_low();
        check("pre_reset_busy", busy, 1'b1);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_start", start, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_A", A, 8'h00);
        repeat (3) tick_low();
        #2;
        reset_n = 1'b1;
        done_mode = 0; done_lat = 3;
        repeat (30) tick_low();
        check("held_no_launch", busy | start, 1'b0);
        key_start_n = 1'b1;
        repeat (10) tick_low();
        sw = 8'h81;
        press(10, 10, 1'b0);
        check("after_release_start", start, 1'b1);
        check("after_release_A", A, 8'h81);

        // randomized presses, bounces, done latencies and switch jitter
        for (int it = 0; it < 60; it++) begin
            done_mode = 0;
            done_lat  = $urandom_range(2, 18);
            sw        = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bounce($urandom_range(1, 3));
            else press($urandom_range(7, 12), $urandom_range(7, 12), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(5, 25)) tick_low();
        end

`ifdef LAUNCH_COUNT_EN
        apply_reset();
        repeat (4) tick_low();
        done_mode = 0; done_lat = 2;
        for (int n = 0; n < 257; n++) press(8, 10, 1'b0);
        check("launch_wrap", launch_count, 8'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
